// File: rtl/video_timing_gen.sv
// Raster timing generator: DE, HSYNC/VSYNC, pixel coordinates and optional colour bars.
// Define VTG_PATTERN_EN to build the 8-bar test pattern; otherwise the pixel data is constant 0.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0
) (
    input  logic        i_pixclk,
    input  logic        i_reset_n,
    input  logic        i_enable,
    output logic        o_de,
    output logic [1:0]  o_ctrl,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue,
    output logic        o_frame_start
);

    localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE - 1);
    localparam logic [11:0] H_FP_END   = 12'(H_ACTIVE + H_FP - 1);
    localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] H_TOT_M1   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE - 1);
    localparam logic [11:0] V_FP_END   = 12'(V_ACTIVE + V_FP - 1);
    localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [11:0] V_TOT_M1   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic [1:0] {StAct, StFront, StSync, StBack} state_e;

    state_e      r_h_state, w_h_state_nxt, r_v_state, w_v_state_nxt;
    logic [11:0] r_h_cnt, r_v_cnt, w_h_cnt_nxt, w_v_cnt_nxt;
    logic        w_h_wrap, w_de, w_hsync, w_vsync;
    logic [7:0]  w_red, w_green, w_blue;

    logic        r_de, r_frame_start;
    logic [1:0]  r_ctrl;
    logic [11:0] r_x, r_y;
    logic [7:0]  r_red, r_green, r_blue;

    always_comb begin
        w_h_wrap      = (r_h_cnt == H_TOT_M1);
        w_h_cnt_nxt   = w_h_wrap ? 12'd0 : r_h_cnt + 12'd1;
        w_v_cnt_nxt   = r_v_cnt;
        w_h_state_nxt = r_h_state;
        w_v_state_nxt = r_v_state;
        if (w_h_wrap) begin
            w_v_cnt_nxt = (r_v_cnt == V_TOT_M1) ? 12'd0 : r_v_cnt + 12'd1;
        end

        unique case (r_h_state)
            StAct:   if (r_h_cnt == H_ACT_END)  w_h_state_nxt = StFront;
            StFront: if (r_h_cnt == H_FP_END)   w_h_state_nxt = StSync;
            StSync:  if (r_h_cnt == H_SYNC_END) w_h_state_nxt = StBack;
            StBack:  if (w_h_wrap)              w_h_state_nxt = StAct;
        endcase

        // Vertical regions change only on the line wrap, so VSYNC edges land on h_cnt = 0.
        if (w_h_wrap) begin
            unique case (r_v_state)
                StAct:   if (r_v_cnt == V_ACT_END)  w_v_state_nxt = StFront;
                StFront: if (r_v_cnt == V_FP_END)   w_v_state_nxt = StSync;
                StSync:  if (r_v_cnt == V_SYNC_END) w_v_state_nxt = StBack;
                StBack:  if (r_v_cnt == V_TOT_M1)   w_v_state_nxt = StAct;
            endcase
        end

        w_de    = (r_h_state == StAct) && (r_v_state == StAct);
        w_hsync = (r_h_state == StSync) ? HS_POL : ~HS_POL;
        w_vsync = (r_v_state == StSync) ? VS_POL : ~VS_POL;
    end

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_h_cnt   <= 12'd0;
            r_v_cnt   <= 12'd0;
            r_h_state <= StAct;
            r_v_state <= StAct;
        end else if (i_enable) begin
            r_h_cnt   <= w_h_cnt_nxt;
            r_v_cnt   <= w_v_cnt_nxt;
            r_h_state <= w_h_state_nxt;
            r_v_state <= w_v_state_nxt;
        end
    end

`ifdef VTG_PATTERN_EN
    localparam logic [11:0] BAR_W_M1 = 12'(H_ACTIVE / 8 - 1);

    logic [11:0] r_bar_px;
    logic [2:0]  r_bar_idx;

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_bar_px  <= 12'd0;
            r_bar_idx <= 3'd0;
        end else if (i_enable) begin
            if (w_h_wrap) begin
                r_bar_px  <= 12'd0;
                r_bar_idx <= 3'd0;
            end else if (r_h_state == StAct) begin
                if (r_bar_px == BAR_W_M1) begin
                    r_bar_px  <= 12'd0;
                    r_bar_idx <= r_bar_idx + 3'd1;
                end else begin
                    r_bar_px <= r_bar_px + 12'd1;
                end
            end
        end
    end

    // Bar order white, yellow, cyan, green, magenta, red, blue, black maps to inverted index bits.
    always_comb begin
        w_red   = {8{~r_bar_idx[1]}};
        w_green = {8{~r_bar_idx[2]}};
        w_blue  = {8{~r_bar_idx[0]}};
    end
`else
    assign w_red   = 8'd0;
    assign w_green = 8'd0;
    assign w_blue  = 8'd0;
`endif

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_de          <= 1'b0;
            r_ctrl        <= {~VS_POL, ~HS_POL};
            r_x           <= 12'd0;
            r_y           <= 12'd0;
            r_red         <= 8'd0;
            r_green       <= 8'd0;
            r_blue        <= 8'd0;
            r_frame_start <= 1'b0;
        end else begin
            r_de          <= i_enable && w_de;
            r_ctrl        <= i_enable ? {w_vsync, w_hsync} : {~VS_POL, ~HS_POL};
            r_x           <= (i_enable && w_de) ? r_h_cnt : 12'd0;
            r_y           <= (i_enable && w_de) ? r_v_cnt : 12'd0;
            r_red         <= (i_enable && w_de) ? w_red : 8'd0;
            r_green       <= (i_enable && w_de) ? w_green : 8'd0;
            r_blue        <= (i_enable && w_de) ? w_blue : 8'd0;
            r_frame_start <= i_enable && (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
        end
    end

    assign o_de          = r_de;
    assign o_ctrl        = r_ctrl;
    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_red         = r_red;
    assign o_green       = r_green;
    assign o_blue        = r_blue;
    assign o_frame_start = r_frame_start;

endmodule
